biriscv_v_alu_seq: RTL and testbench



---
 rtl/biriscv_v_alu_seq_pkg.sv | 98 +++++++++
 rtl/biriscv_v_alu_seq_lane.sv | 64 ++++++
 rtl/biriscv_v_alu_seq.sv | 158 +++++++++++++++
 tb/tb_biriscv_v_alu_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biriscv_v_alu_seq_pkg.sv
// Shared decode constants, types and per-element ALU helper for the vector integer ALU.
package biriscv_v_alu_seq_pkg;

    localparam logic [6:0] OpcOpv = 7'b1010111;

    localparam logic [2:0] F3Vv = 3'b000;
    localparam logic [2:0] F3Vx = 3'b100;
    localparam logic [2:0] F3Vi = 3'b011;

    localparam logic [1:0] Sew8   = 2'b00;
    localparam logic [1:0] Sew16  = 2'b01;
    localparam logic [1:0] Sew32  = 2'b10;
    localparam logic [1:0] SewBad = 2'b11;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluRsub, AluMinu, AluMin, AluMaxu, AluMax, AluAnd, AluOr, AluXor
    } alu_op_e;

    typedef enum logic [1:0] {BVv, BVx, BVi} b_sel_e;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    typedef struct packed {
        logic    legal;
        alu_op_e op;
        b_sel_e  bsel;
    } dec_t;

    function automatic dec_t decode(logic [31:0] insn, logic [1:0] sew);
        dec_t d;
        logic [2:0] f3;
        f3      = insn[14:12];
        d.legal = (insn[6:0] == OpcOpv) && (sew != SewBad);
        d.op    = AluAdd;
        d.bsel  = BVv;
        case (insn[31:26])
            6'b000000: d.op = AluAdd;
            6'b000010: d.op = AluSub;
            6'b000011: d.op = AluRsub;
            6'b000100: d.op = AluMinu;
            6'b000101: d.op = AluMin;
            6'b000110: d.op = AluMaxu;
            6'b000111: d.op = AluMax;
            6'b001001: d.op = AluAnd;
            6'b001010: d.op = AluOr;
            6'b001011: d.op = AluXor;
            default:   d.legal = 1'b0;
        endcase
        case (f3)
            F3Vv:    d.bsel = BVv;
            F3Vx:    d.bsel = BVx;
            F3Vi:    d.bsel = BVi;
            default: d.legal = 1'b0;
        endcase
        if (f3 == F3Vi && d.op inside {AluSub, AluMinu, AluMin, AluMaxu, AluMax}) d.legal = 1'b0;
        if (f3 == F3Vv && d.op == AluRsub) d.legal = 1'b0;
        return d;
    endfunction

    // a and b arrive zero-extended; MSB-aligning them lets one 32-bit compare serve every SEW.
    function automatic logic [31:0] alu_elem(alu_op_e op, logic [1:0] sew,
                                             logic [31:0] a, logic [31:0] b);
        logic [31:0] aa;
        logic [31:0] ba;
        logic        lt_u;
        logic        lt_s;
        case (sew)
            Sew8: begin
                aa = a << 24;
                ba = b << 24;
            end
            Sew16: begin
                aa = a << 16;
                ba = b << 16;
            end
            default: begin
                aa = a;
                ba = b;
            end
        endcase
        lt_u = aa < ba;
        lt_s = $signed(aa) < $signed(ba);
        case (op)
            AluAdd:  return a + b;
            AluSub:  return a - b;
            AluRsub: return b - a;
            AluMinu: return lt_u ? a : b;
            AluMin:  return lt_s ? a : b;
            AluMaxu: return lt_u ? b : a;
            AluMax:  return lt_s ? b : a;
            AluAnd:  return a & b;
            AluOr:   return a | b;
            AluXor:  return a ^ b;
            default: return a;
        endcase
    endfunction

endpackage

// File: rtl/biriscv_v_alu_seq_lane.sv
// Combinational BW-bit beat slice: per-element ALU plus tail/mask merge with old vd contents.
module biriscv_v_alu_seq_lane
    import biriscv_v_alu_seq_pkg::*;
#(
    parameter int unsigned BW   = 64,
    parameter int unsigned IdxW = 5
) (
    input  logic [3:0]      op_i,
    input  logic [1:0]      sew_i,
    input  logic            b_vv_i,
    input  logic [31:0]     scalar_i,
    input  logic            vm_i,
    input  logic [BW/8-1:0] mask_i,
    input  logic [IdxW-1:0] elem_base_i,
    input  logic [IdxW-1:0] vl_eff_i,
    input  logic [BW-1:0]   vs2_i,
    input  logic [BW-1:0]   vs1_i,
    input  logic [BW-1:0]   vd_old_i,
    output logic [BW-1:0]   res_o
);

    logic [BW/8-1:0] act;
    logic [31:0]     r;
    alu_op_e         op;

    assign op = alu_op_e'(op_i);

    // Activity depends only on element index within the beat, not on SEW.
    always_comb begin
        for (int e = 0; e < BW / 8; e++) begin
            act[e] = (32'(elem_base_i) + 32'(e) < 32'(vl_eff_i)) && (vm_i || mask_i[e]);
        end
    end

    always_comb begin
        res_o = vd_old_i;
        r     = '0;
        unique case (sew_i)
            Sew8: begin
                for (int e = 0; e < BW / 8; e++) begin
                    r = alu_elem(op, sew_i, 32'(vs2_i[e*8 +: 8]),
                                 b_vv_i ? 32'(vs1_i[e*8 +: 8]) : 32'(scalar_i[7:0]));
                    if (act[e]) res_o[e*8 +: 8] = r[7:0];
                end
            end
            Sew16: begin
                for (int e = 0; e < BW / 16; e++) begin
                    r = alu_elem(op, sew_i, 32'(vs2_i[e*16 +: 16]),
                                 b_vv_i ? 32'(vs1_i[e*16 +: 16]) : 32'(scalar_i[15:0]));
                    if (act[e]) res_o[e*16 +: 16] = r[15:0];
                end
            end
            Sew32: begin
                for (int e = 0; e < BW / 32; e++) begin
                    r = alu_elem(op, sew_i, vs2_i[e*32 +: 32],
                                 b_vv_i ? vs1_i[e*32 +: 32] : scalar_i);
                    if (act[e]) res_o[e*32 +: 32] = r;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/biriscv_v_alu_seq.sv
// Multi-cycle vector integer ALU: accepts one request, runs NB beats through one lane slice,
// then holds the result until writeback accepts it.
module biriscv_v_alu_seq
    import biriscv_v_alu_seq_pkg::*;
#(
    parameter int unsigned VLEN  = 128,
    parameter int unsigned ELEN  = 32,
    parameter int unsigned LANES = 2,
    localparam int unsigned VlW  = $clog2(VLEN / 8) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     opcode_i,
    input  logic [1:0]      sew_i,
    input  logic [VlW-1:0]  vl_i,
    input  logic [31:0]     rs1_i,
    input  logic [VLEN-1:0] vs2_i,
    input  logic [VLEN-1:0] vs1_i,
    input  logic [VLEN-1:0] vd_old_i,
    input  logic [VLEN-1:0] vmask_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [VLEN-1:0] wb_value_o,
    output logic            wb_illegal_o
);

    localparam int unsigned BW    = LANES * ELEN;
    localparam int unsigned NB    = VLEN / BW;
    localparam int unsigned BeatW = (NB > 1) ? $clog2(NB) : 1;

    state_e          state_q, state_d;
    logic [BeatW-1:0] beat_q, beat_d;
    alu_op_e         op_q, op_d;
    logic [1:0]      sew_q, sew_d;
    logic            b_vv_q, b_vv_d;
    logic            vm_q, vm_d;
    logic [31:0]     scalar_q, scalar_d;
    logic [VlW-1:0]  vl_eff_q, vl_eff_d;
    logic [VLEN-1:0] vs2_q, vs2_d, vs1_q, vs1_d, vmask_q, vmask_d, res_q, res_d;
    logic            illegal_q, illegal_d;

    dec_t            dec;
    logic [VlW-1:0]  vlmax, vl_eff_in, elem_base;
    logic [BW/8-1:0] mask_slice;
    logic [BW-1:0]   lane_res;

    assign dec = decode(opcode_i, sew_i);

    always_comb begin
        vlmax     = VlW'(VLEN >> (32'd3 + 32'(sew_i)));
        vl_eff_in = (vl_i < vlmax) ? vl_i : vlmax;
    end

    assign elem_base  = VlW'((32'(beat_q) * BW) >> (32'd3 + 32'(sew_q)));
    assign mask_slice = vmask_q[elem_base +: BW/8];

    biriscv_v_alu_seq_lane #(
        .BW   (BW),
        .IdxW (VlW)
    ) u_lane (
        .op_i        (op_q),
        .sew_i       (sew_q),
        .b_vv_i      (b_vv_q),
        .scalar_i    (scalar_q),
        .vm_i        (vm_q),
        .mask_i      (mask_slice),
        .elem_base_i (elem_base),
        .vl_eff_i    (vl_eff_q),
        .vs2_i       (vs2_q[32'(beat_q) * BW +: BW]),
        .vs1_i       (vs1_q[32'(beat_q) * BW +: BW]),
        .vd_old_i    (res_q[32'(beat_q) * BW +: BW]),
        .res_o       (lane_res)
    );

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        op_d      = op_q;
        sew_d     = sew_q;
        b_vv_d    = b_vv_q;
        vm_d      = vm_q;
        scalar_d  = scalar_q;
        vl_eff_d  = vl_eff_q;
        vs2_d     = vs2_q;
        vs1_d     = vs1_q;
        vmask_d   = vmask_q;
        res_d     = res_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    op_d      = dec.op;
                    sew_d     = sew_i;
                    b_vv_d    = (dec.bsel == BVv);
                    vm_d      = opcode_i[25];
                    scalar_d  = (dec.bsel == BVi) ? {{27{opcode_i[19]}}, opcode_i[19:15]} : rs1_i;
                    vl_eff_d  = vl_eff_in;
                    vs2_d     = vs2_i;
                    vs1_d     = vs1_i;
                    vmask_d   = vmask_i;
                    res_d     = vd_old_i;
                    illegal_d = !dec.legal;
                    beat_d    = '0;
                    state_d   = (dec.legal && vl_eff_in != '0) ? StExec : StDone;
                end
            end
            StExec: begin
                res_d[32'(beat_q) * BW +: BW] = lane_res;
                if (32'(beat_q) == NB - 1) state_d = StDone;
                else                       beat_d  = beat_q + 1'b1;
            end
            StDone: begin
                if (wb_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            op_q      <= AluAdd;
            sew_q     <= Sew8;
            b_vv_q    <= 1'b0;
            vm_q      <= 1'b0;
            scalar_q  <= '0;
            vl_eff_q  <= '0;
            vs2_q     <= '0;
            vs1_q     <= '0;
            vmask_q   <= '0;
            res_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            op_q      <= op_d;
            sew_q     <= sew_d;
            b_vv_q    <= b_vv_d;
            vm_q      <= vm_d;
            scalar_q  <= scalar_d;
            vl_eff_q  <= vl_eff_d;
            vs2_q     <= vs2_d;
            vs1_q     <= vs1_d;
            vmask_q   <= vmask_d;
            res_q     <= res_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready_o   = (state_q == StIdle);
    assign wb_valid_o   = (state_q == StDone);
    assign wb_value_o   = res_q;
    assign wb_illegal_o = illegal_q;

endmodule

// File: tb/tb_biriscv_v_alu_seq.sv
// Randomized self-checking bench for biriscv_v_alu_seq against an element-level reference model.
module tb_biriscv_v_alu_seq;

    localparam int VLEN = 128;
    localparam int NB   = 2;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [31:0]  opcode_i;
    logic [1:0]   sew_i;
    logic [4:0]   vl_i;
    logic [31:0]  rs1_i;
    logic [127:0] vs2_i, vs1_i, vd_old_i, vmask_i;
    logic         wb_valid_o;
    logic         wb_ready_i;
    logic [127:0] wb_value_o;
    logic         wb_illegal_o;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_val;
    logic         exp_ill;
    int           exp_lat;
    int           lat_cnt;
    bit           pending = 0;
    bit           seen = 0;

    biriscv_v_alu_seq dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .opcode_i     (opcode_i),
        .sew_i        (sew_i),
        .vl_i         (vl_i),
        .rs1_i        (rs1_i),
        .vs2_i        (vs2_i),
        .vs1_i        (vs1_i),
        .vd_old_i     (vd_old_i),
        .vmask_i      (vmask_i),
        .wb_valid_o   (wb_valid_o),
        .wb_ready_i   (wb_ready_i),
        .wb_value_o   (wb_value_o),
        .wb_illegal_o (wb_illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, expv);
        end
    endtask

    function automatic logic [31:0] mk(logic [5:0] f6, logic vm, logic [2:0] f3, logic [4:0] s1);
        return {f6, vm, 5'd2, s1, f3, 5'd3, 7'b1010111};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: walk elements, apply op with plain integer arithmetic, merge into old vd.
    function automatic void model(input logic [31:0] insn, input logic [1:0] sew,
                                  input logic [4:0] vl, input logic [31:0] rs1,
                                  input logic [127:0] vs2, input logic [127:0] vs1,
                                  input logic [127:0] old, input logic [127:0] m,
                                  output logic [127:0] res, output logic ill, output int lat);
        int w, vlmax, vle;
        logic [5:0] f6;
        logic [2:0] f3;
        bit ok;
        longint unsigned msk, a, b, r;
        longint sa, sb;
        f6  = insn[31:26];
        f3  = insn[14:12];
        ok  = (insn[6:0] == 7'h57) && (sew != 2'd3) && (f3 == 3'd0 || f3 == 3'd4 || f3 == 3'd3);
        case (f6)
            6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd11: ;
            default: ok = 0;
        endcase
        if (f3 == 3'd3 && (f6 == 6'd2 || (f6 >= 6'd4 && f6 <= 6'd7))) ok = 0;
        if (f3 == 3'd0 && f6 == 6'd3) ok = 0;
        res = old;
        ill = !ok;
        lat = 1;
        if (!ok) return;
        w     = 8 << sew;
        vlmax = VLEN / w;
        vle   = (int'(vl) < vlmax) ? int'(vl) : vlmax;
        if (vle > 0) lat = NB + 1;
        msk = (64'd1 << w) - 1;
        for (int i = 0; i < vle; i++) begin
            if (insn[25] || m[i]) begin
                a = 64'(vs2 >> (i * w)) & msk;
                if (f3 == 3'd0)      b = 64'(vs1 >> (i * w)) & msk;
                else if (f3 == 3'd4) b = 64'(rs1) & msk;
                else                 b = longint'($signed(insn[19:15])) & msk;
                sa = (a > (msk >> 1)) ? longint'(a) - longint'(msk) - 1 : longint'(a);
                sb = (b > (msk >> 1)) ? longint'(b) - longint'(msk) - 1 : longint'(b);
                case (f6)
                    6'd0:    r = a + b;
                    6'd2:    r = a - b;
                    6'd3:    r = b - a;
                    6'd4:    r = (a < b) ? a : b;
                    6'd5:    r = (sa < sb) ? a : b;
                    6'd6:    r = (a > b) ? a : b;
                    6'd7:    r = (sa > sb) ? a : b;
                    6'd9:    r = a & b;
                    6'd10:   r = a | b;
                    default: r = a ^ b;
                endcase
                res = (res & ~(128'(msk) << (i * w))) | (128'(r & msk) << (i * w));
            end
        end
    endfunction

    // Single compare process: result/handshake checks on every cycle a request is in flight.
    always @(negedge clk_i) begin
        if (pending) begin
            lat_cnt = lat_cnt + 1;
            if (wb_valid_o) begin
                if (!seen) begin
                    chk("latency", 128'(lat_cnt), 128'(exp_lat));
                    seen = 1;
                end
                chk("wb_value", wb_value_o, exp_val);
                chk("wb_illegal", 128'(wb_illegal_o), 128'(exp_ill));
                chk("ready_while_done", 128'(in_ready_o), 128'(0));
            end else begin
                chk("ready_while_busy", 128'(in_ready_o), 128'(0));
            end
        end else if (rst_ni) begin
            chk("idle_valid", 128'(wb_valid_o), 128'(0));
            chk("idle_ready", 128'(in_ready_o), 128'(1));
        end
    end

    task automatic scramble();
        opcode_i = $urandom;
        sew_i    = 2'($urandom);
        vl_i     = 5'($urandom);
        rs1_i    = $urandom;
        vs2_i    = rnd128();
        vs1_i    = rnd128();
        vd_old_i = rnd128();
        vmask_i  = rnd128();
    endtask

    task automatic do_req(input logic [31:0] insn, input logic [1:0] sew, input logic [4:0] vl,
                          input logic [31:0] rs1, input logic [127:0] a, input logic [127:0] b,
                          input logic [127:0] old, input logic [127:0] m, input int hold);
        model(insn, sew, vl, rs1, a, b, old, m, exp_val, exp_ill, exp_lat);
        @(posedge clk_i); #1;
        opcode_i = insn; sew_i = sew; vl_i = vl; rs1_i = rs1;
        vs2_i = a; vs1_i = b; vd_old_i = old; vmask_i = m;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        scramble();
        seen    = 0;
        lat_cnt = 0;
        pending = 1;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk_i); #1;
        end
        chk("wb_valid_seen", 128'(seen), 128'(1));
        repeat (hold) @(negedge clk_i);
        @(posedge clk_i); #1;
        wb_ready_i = 1'b1;
        @(posedge clk_i); #1;
        wb_ready_i = 1'b0;
        pending    = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r;
        logic         il;
        int           lt;
        logic [31:0]  insn;
        logic [5:0]   f6;
        logic [2:0]   f3;
        logic [1:0]   sw;
        int           k;
        logic [5:0]   f6_list [10];
        f6_list = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd11};

        rst_ni = 1'b0; in_valid_i = 1'b0; wb_ready_i = 1'b0;
        opcode_i = '0; sew_i = '0; vl_i = '0; rs1_i = '0;
        vs2_i = '0; vs1_i = '0; vd_old_i = '0; vmask_i = '0;
        #12;
        chk("rst_valid", 128'(wb_valid_o), 128'(0));
        chk("rst_ready", 128'(in_ready_o), 128'(1));
        chk("rst_value", wb_value_o, 128'(0));
        chk("rst_illegal", 128'(wb_illegal_o), 128'(0));
        @(negedge clk_i); rst_ni = 1'b1;

        // vadd.vv SEW=32
        insn = mk(6'd0, 1'b1, 3'b000, 5'd0);
        model(insn, 2'd2, 5'd4, 0, 128'h00000004_00000003_00000002_00000001,
              128'h00000028_0000001E_00000014_0000000A, '0, '0, r, il, lt);
        chk("pin_vadd", r, 128'h0000002C_00000021_00000016_0000000B);
        chk("pin_vadd_lat", 128'(lt), 128'(3));
        do_req(insn, 2'd2, 5'd4, 0, 128'h00000004_00000003_00000002_00000001,
               128'h00000028_0000001E_00000014_0000000A, '0, '0, 0);

        // vsub.vx SEW=8, vl=5
        insn = mk(6'd2, 1'b1, 3'b100, 5'd0);
        model(insn, 2'd0, 5'd5, 32'h01, '0, '0, {16{8'hAA}}, '0, r, il, lt);
        chk("pin_vsubvx", r, 128'hAAAAAAAAAAAAAAAAAAAAAAFFFFFFFFFF);
        do_req(insn, 2'd0, 5'd5, 32'h01, '0, '0, {16{8'hAA}}, '0, 0);

        // vrsub.vi SEW=16, simm5=-1, masked
        insn = mk(6'd3, 1'b0, 3'b011, 5'h1F);
        model(insn, 2'd1, 5'd8, 0, {8{16'h0001}}, '0, {8{16'h5555}}, 128'h5, r, il, lt);
        chk("pin_vrsubvi", r, 128'h5555_5555_5555_5555_5555_FFFE_5555_FFFE);
        do_req(insn, 2'd1, 5'd8, 0, {8{16'h0001}}, '0, {8{16'h5555}}, 128'h5, 0);

        // vmin vs vminu
        insn = mk(6'd5, 1'b1, 3'b000, 5'd0);
        model(insn, 2'd2, 5'd4, 0, {4{32'hFFFFFFFF}}, {4{32'h1}}, '0, '0, r, il, lt);
        chk("pin_vmin", r, {4{32'hFFFFFFFF}});
        do_req(insn, 2'd2, 5'd4, 0, {4{32'hFFFFFFFF}}, {4{32'h1}}, '0, '0, 0);
        insn = mk(6'd4, 1'b1, 3'b000, 5'd0);
        model(insn, 2'd2, 5'd4, 0, {4{32'hFFFFFFFF}}, {4{32'h1}}, '0, '0, r, il, lt);
        chk("pin_vminu", r, {4{32'h1}});
        do_req(insn, 2'd2, 5'd4, 0, {4{32'hFFFFFFFF}}, {4{32'h1}}, '0, '0, 0);

        // Illegal forms and vl=0
        insn = mk(6'd2, 1'b1, 3'b011, 5'd3);
        model(insn, 2'd0, 5'd16, 0, rnd128(), rnd128(), 128'h1234, '0, r, il, lt);
        chk("pin_vsubvi_ill", 128'(il), 128'(1));
        chk("pin_vsubvi_lat", 128'(lt), 128'(1));
        do_req(insn, 2'd0, 5'd16, 0, rnd128(), rnd128(), rnd128(), '0, 0);
        do_req(mk(6'd0, 1'b1, 3'b000, 5'd0), 2'd3, 5'd4, 0, rnd128(), rnd128(), rnd128(), '0, 0);
        insn = mk(6'd0, 1'b1, 3'b000, 5'd0);
        model(insn, 2'd2, 5'd0, 0, rnd128(), rnd128(), 128'hBEEF, '0, r, il, lt);
        chk("pin_vl0_ill", 128'(il), 128'(0));
        chk("pin_vl0_val", r, 128'hBEEF);
        do_req(insn, 2'd2, 5'd0, 0, rnd128(), rnd128(), rnd128(), '0, 0);

        // Back-pressure
        do_req(mk(6'd11, 1'b1, 3'b000, 5'd0), 2'd1, 5'd8, 0, rnd128(), rnd128(), rnd128(), '0, 10);

        // Reset while in EXEC discards the request
        @(posedge clk_i); #1;
        opcode_i = mk(6'd0, 1'b1, 3'b000, 5'd0); sew_i = 2'd2; vl_i = 5'd4;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("midrst_valid", 128'(wb_valid_o), 128'(0));
        chk("midrst_ready", 128'(in_ready_o), 128'(1));
        chk("midrst_value", wb_value_o, 128'(0));
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk_i);

        for (int n = 0; n < 150; n++) begin
            k  = $urandom_range(0, 9);
            f6 = ($urandom_range(0, 9) == 0) ? 6'($urandom) : f6_list[k];
            k  = $urandom_range(0, 9);
            f3 = (k < 4) ? 3'b000 : (k < 7) ? 3'b100 : (k < 9) ? 3'b011 : 3'($urandom);
            insn = {f6, 1'($urandom), 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b1010111};
            if ($urandom_range(0, 19) == 0) insn[6:0] = 7'($urandom);
            k  = $urandom_range(0, 9);
            sw = (k < 3) ? 2'd0 : (k < 6) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
            do_req(insn, sw, 5'($urandom_range(0, 20)), $urandom, rnd128(), rnd128(), rnd128(),
                   rnd128(), $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
